// File: rtl/hht_pkg.sv
// hht_pkg
// Shared definitions for the HHT sparse-matrix datapath.
// Holds the default width constants for the CSR engine and the state
// encoding of its sequencing FSM.  No ports; imported by csr_spmv_ctrl.
package hht_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 32;
    localparam int DEF_IDX_W  = 16;
    localparam int DEF_ACC_W  = 64;

    // Sequencing states of the CSR walker.
    typedef enum logic [2:0] {
        IDLE,
        PTR0,
        PTR,
        COL,
        VEC,
        EMIT,
        DONE
    } state_t;

endpackage

// File: rtl/spmv_mac.sv
// spmv_mac
// Registered multiply-accumulate used by the CSR engine for one row's dot
// product.  The unsigned product is widened to ACC_W and added with
// modulo-2^ACC_W wrap.
//   clk_i, rst_ni : clock and asynchronous active-low reset
//   clear_i       : zero the accumulator (has priority over en_i)
//   en_i          : add a_i*b_i into the accumulator
//   a_i, b_i      : DATA_W-bit unsigned operands
//   acc_o         : registered accumulator value
module spmv_mac #(
    parameter int DATA_W = 32,
    parameter int ACC_W  = 64
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clear_i,
    input  logic              en_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic [ACC_W-1:0]  acc_o
);

    logic [2*DATA_W-1:0] prod;
    logic [ACC_W-1:0]    acc_q;
    logic [ACC_W-1:0]    acc_d;

    // Full-width unsigned product; operands are zero-extended first so the
    // multiply is evaluated at 2*DATA_W bits.
    assign prod = {{DATA_W{1'b0}}, a_i} * {{DATA_W{1'b0}}, b_i};

    // Next accumulator value: clear wins over accumulate, otherwise hold.
    always_comb begin
        acc_d = acc_q;
        if (clear_i) begin
            acc_d = '0;
        end else if (en_i) begin
            acc_d = acc_q + ACC_W'(prod);
        end
    end

    // Accumulator register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/csr_spmv_ctrl.sv
// csr_spmv_ctrl
// CSR sparse-matrix x dense-vector engine.  Walks the row-pointer,
// column-index, value and vector arrays through two combinational-read
// memory ports and streams one dot product per row on a valid/ready port.
//   Clk, Rst                         : clock, asynchronous active-low reset
//   start                            : begin a job (sampled only in IDLE)
//   n_rows, n_cols                   : matrix dimensions, latched at start
//   row_base/col_base/val_base/vec_base : array base addresses, latched at start
//   addr1, rd1, dataIn1              : port 1, row pointers and column indices
//   addr2, rd2, dataIn2              : port 2, values and vector entries
//   busy, done                       : job active, one-cycle completion pulse
//   y_valid, y_ready, y_row, y_data  : result stream
//   err                              : sticky out-of-range column flag
module csr_spmv_ctrl
    import hht_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int IDX_W  = DEF_IDX_W,
    parameter int ACC_W  = DEF_ACC_W
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              start,
    input  logic [IDX_W-1:0]  n_rows,
    input  logic [IDX_W-1:0]  n_cols,
    input  logic [ADDR_W-1:0] row_base,
    input  logic [ADDR_W-1:0] col_base,
    input  logic [ADDR_W-1:0] val_base,
    input  logic [ADDR_W-1:0] vec_base,
    output logic [ADDR_W-1:0] addr1,
    output logic              rd1,
    input  logic [DATA_W-1:0] dataIn1,
    output logic [ADDR_W-1:0] addr2,
    output logic              rd2,
    input  logic [DATA_W-1:0] dataIn2,
    output logic              busy,
    output logic              done,
    output logic              y_valid,
    input  logic              y_ready,
    output logic [IDX_W-1:0]  y_row,
    output logic [ACC_W-1:0]  y_data,
    output logic              err
);

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  nRows_q, nCols_q;
    logic [ADDR_W-1:0] rowBase_q, colBase_q, valBase_q, vecBase_q;
    logic [IDX_W-1:0]  r_q, r_d;
    logic [ADDR_W-1:0] k_q, k_d;
    logic [ADDR_W-1:0] kend_q, kend_d;
    logic [IDX_W-1:0]  col_q, col_d;
    logic [DATA_W-1:0] val_q, val_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] addr1Hold_q, addr2Hold_q;

    logic [ADDR_W-1:0] addr1Now, addr2Now;
    logic              rd1Now, rd2Now;
    logic              loadCfg;
    logic              macClear, macEn;
    logic [ACC_W-1:0]  acc;

    // Memory words reinterpreted as pointers / column indices (low bits, or
    // zero-extended when the data word is narrower).
    logic [ADDR_W-1:0] ptrIn;
    logic [IDX_W-1:0]  colIn;
    logic [ADDR_W-1:0] kNext;
    logic [IDX_W-1:0]  rNext;

    assign ptrIn = ADDR_W'(dataIn1);
    assign colIn = IDX_W'(dataIn1);
    assign kNext = k_q + 1'b1;
    assign rNext = r_q + 1'b1;

    // Next-state, datapath updates and memory port drive.  Address outputs
    // default to the held value so they keep their last address whenever
    // the corresponding read strobe is low.
    always_comb begin
        state_d  = state_q;
        r_d      = r_q;
        k_d      = k_q;
        kend_d   = kend_q;
        col_d    = col_q;
        val_d    = val_q;
        err_d    = err_q;
        rd1Now   = 1'b0;
        rd2Now   = 1'b0;
        addr1Now = addr1Hold_q;
        addr2Now = addr2Hold_q;
        loadCfg  = 1'b0;
        macClear = 1'b0;
        macEn    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    loadCfg = 1'b1;
                    err_d   = 1'b0;
                    r_d     = '0;
                    state_d = PTR0;
                end
            end
            PTR0: begin
                rd1Now   = 1'b1;
                addr1Now = rowBase_q;
                k_d      = ptrIn;
                state_d  = (nRows_q == '0) ? DONE : PTR;
            end
            PTR: begin
                rd1Now   = 1'b1;
                addr1Now = rowBase_q + ADDR_W'(r_q) + 1'b1;
                kend_d   = ptrIn;
                macClear = 1'b1;
                state_d  = (k_q == ptrIn) ? EMIT : COL;
            end
            COL: begin
                rd1Now   = 1'b1;
                rd2Now   = 1'b1;
                addr1Now = colBase_q + k_q;
                addr2Now = valBase_q + k_q;
                col_d    = colIn;
                val_d    = dataIn2;
                // Out-of-range column: flag it and skip the vector read.
                if (colIn >= nCols_q) begin
                    err_d   = 1'b1;
                    k_d     = kNext;
                    state_d = (kNext != kend_q) ? COL : EMIT;
                end else begin
                    state_d = VEC;
                end
            end
            VEC: begin
                rd2Now   = 1'b1;
                addr2Now = vecBase_q + ADDR_W'(col_q);
                macEn    = 1'b1;
                k_d      = kNext;
                state_d  = (kNext != kend_q) ? COL : EMIT;
            end
            EMIT: begin
                if (y_ready) begin
                    r_d     = rNext;
                    state_d = (rNext == nRows_q) ? DONE : PTR;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM state, row/pointer counters, latched column/value and error flag.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q     <= IDLE;
            r_q         <= '0;
            k_q         <= '0;
            kend_q      <= '0;
            col_q       <= '0;
            val_q       <= '0;
            err_q       <= 1'b0;
            addr1Hold_q <= '0;
            addr2Hold_q <= '0;
        end else begin
            state_q     <= state_d;
            r_q         <= r_d;
            k_q         <= k_d;
            kend_q      <= kend_d;
            col_q       <= col_d;
            val_q       <= val_d;
            err_q       <= err_d;
            addr1Hold_q <= addr1Now;
            addr2Hold_q <= addr2Now;
        end
    end

    // Job configuration, captured only when a start is accepted so that
    // input changes during a job have no effect.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            nRows_q   <= '0;
            nCols_q   <= '0;
            rowBase_q <= '0;
            colBase_q <= '0;
            valBase_q <= '0;
            vecBase_q <= '0;
        end else if (loadCfg) begin
            nRows_q   <= n_rows;
            nCols_q   <= n_cols;
            rowBase_q <= row_base;
            colBase_q <= col_base;
            valBase_q <= val_base;
            vecBase_q <= vec_base;
        end
    end

    spmv_mac #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) uMac (
        .clk_i   (Clk),
        .rst_ni  (Rst),
        .clear_i (macClear),
        .en_i    (macEn),
        .a_i     (val_q),
        .b_i     (dataIn2),
        .acc_o   (acc)
    );

    assign addr1   = addr1Now;
    assign addr2   = addr2Now;
    assign rd1     = rd1Now;
    assign rd2     = rd2Now;
    assign busy    = (state_q != IDLE) && (state_q != DONE);
    assign done    = (state_q == DONE);
    assign y_valid = (state_q == EMIT);
    assign y_row   = r_q;
    assign y_data  = acc;
    assign err     = err_q;

endmodule

// File: tb/tb_csr_spmv_ctrl.sv
// tb_csr_spmv_ctrl
// Bench for csr_spmv_ctrl: a 32-bit instance driven from a table of jobs on
// a small CSR matrix, hand-written reset/abort and address sequences, and an
// 8-bit-data instance exercising accumulator wrap.
module tb_csr_spmv_ctrl;

    logic Clk = 1'b0;
    logic Rst;

    // 32-bit instance signals
    logic        start;
    logic [15:0] n_rows, n_cols;
    logic [31:0] row_base, col_base, val_base, vec_base;
    logic [31:0] addr1, addr2, dataIn1, dataIn2;
    logic        rd1, rd2, busy, done, y_valid, y_ready, err;
    logic [15:0] y_row;
    logic [63:0] y_data;

    // 8-bit instance signals
    logic        start8;
    logic [15:0] n_rows8, n_cols8;
    logic [31:0] addr1_8, addr2_8;
    logic [7:0]  dataIn1_8, dataIn2_8;
    logic        rd1_8, rd2_8, busy8, done8, y_valid8, y_ready8, err8;
    logic [15:0] y_row8;
    logic [15:0] y_data8;

    logic [31:0] mem  [0:4095];
    logic [7:0]  mem8 [0:255];

    int checks = 0;
    int errors = 0;

    typedef struct {
        int              nRows;
        int              nCols;
        logic [31:0]     col2;
        int              stallRow;
        int              stallLen;
        int              restartEdge;
        int              expCount;
        logic [2:0][63:0] expY;
        logic            expErr;
        int              expFirstValid;
        int              expDoneEdge;
    } vec_t;

    vec_t vecs [6];

    // Clock: 10 time-unit period.
    always #5 Clk = ~Clk;

    // Combinational-read memories.
    assign dataIn1   = mem[addr1[11:0]];
    assign dataIn2   = mem[addr2[11:0]];
    assign dataIn1_8 = mem8[addr1_8[7:0]];
    assign dataIn2_8 = mem8[addr2_8[7:0]];

    csr_spmv_ctrl dut (
        .Clk(Clk), .Rst(Rst), .start(start),
        .n_rows(n_rows), .n_cols(n_cols),
        .row_base(row_base), .col_base(col_base),
        .val_base(val_base), .vec_base(vec_base),
        .addr1(addr1), .rd1(rd1), .dataIn1(dataIn1),
        .addr2(addr2), .rd2(rd2), .dataIn2(dataIn2),
        .busy(busy), .done(done),
        .y_valid(y_valid), .y_ready(y_ready), .y_row(y_row), .y_data(y_data),
        .err(err)
    );

    csr_spmv_ctrl #(.DATA_W(8), .ADDR_W(32), .IDX_W(16), .ACC_W(16)) dut8 (
        .Clk(Clk), .Rst(Rst), .start(start8),
        .n_rows(n_rows8), .n_cols(n_cols8),
        .row_base(32'h10), .col_base(32'h20),
        .val_base(32'h30), .vec_base(32'h40),
        .addr1(addr1_8), .rd1(rd1_8), .dataIn1(dataIn1_8),
        .addr2(addr2_8), .rd2(rd2_8), .dataIn2(dataIn2_8),
        .busy(busy8), .done(done8),
        .y_valid(y_valid8), .y_ready(y_ready8), .y_row(y_row8), .y_data(y_data8),
        .err(err8)
    );

    function automatic vec_t mkVec(int nR, int nC, logic [31:0] c2, int sRow, int sLen,
                                   int rs, int cnt, logic [63:0] y0, logic [63:0] y1,
                                   logic [63:0] y2, logic e, int fv, int de);
        vec_t v;
        v.nRows = nR; v.nCols = nC; v.col2 = c2;
        v.stallRow = sRow; v.stallLen = sLen; v.restartEdge = rs;
        v.expCount = cnt;
        v.expY[0] = y0; v.expY[1] = y1; v.expY[2] = y2;
        v.expErr = e; v.expFirstValid = fv; v.expDoneEdge = de;
        return v;
    endfunction

    // One comparison; reports and counts a mismatch.
    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Runs one table job end to end and compares the collected results.
    task automatic applyStimulus(input int idx);
        vec_t        v;
        int          e;
        int          doneEdge;
        int          firstValid;
        int          stallLeft;
        logic [15:0] gotRow [$];
        logic [63:0] gotData [$];
        v = vecs[idx];
        mem[12'h202] = v.col2;
        n_rows  = 16'(v.nRows);
        n_cols  = 16'(v.nCols);
        y_ready = 1'b1;
        start   = 1'b1;
        tick();
        start = 1'b0;
        e = 0; doneEdge = -1; firstValid = -1; stallLeft = v.stallLen;
        checkOutput($sformatf("v%0d_busy_rise", idx), 64'(busy), 64'd1);
        while (e < 100 && doneEdge < 0) begin
            start  = (e == v.restartEdge);
            n_rows = (e == v.restartEdge) ? 16'd1 : 16'(v.nRows);
            if (done) begin
                doneEdge = e;
                checkOutput($sformatf("v%0d_busy_at_done", idx), 64'(busy), 64'd0);
            end
            if (y_valid) begin
                if (firstValid < 0) firstValid = e;
                if (int'(y_row) == v.stallRow && stallLeft > 0) begin
                    y_ready = 1'b0;
                    stallLeft--;
                    checkOutput($sformatf("v%0d_stall_rd1", idx), 64'(rd1), 64'd0);
                    checkOutput($sformatf("v%0d_stall_rd2", idx), 64'(rd2), 64'd0);
                    checkOutput($sformatf("v%0d_stall_row", idx), 64'(y_row), 64'(v.stallRow));
                    checkOutput($sformatf("v%0d_stall_data", idx), y_data, v.expY[v.stallRow]);
                end else begin
                    y_ready = 1'b1;
                    gotRow.push_back(y_row);
                    gotData.push_back(y_data);
                end
            end else begin
                y_ready = 1'b1;
            end
            if (doneEdge < 0) begin
                tick();
                e++;
            end
        end
        start   = 1'b0;
        y_ready = 1'b1;
        checkOutput($sformatf("v%0d_done_edge", idx), 64'(doneEdge), 64'(v.expDoneEdge));
        checkOutput($sformatf("v%0d_first_valid", idx), 64'(firstValid), 64'(v.expFirstValid));
        checkOutput($sformatf("v%0d_count", idx), 64'(gotRow.size()), 64'(v.expCount));
        for (int j = 0; j < v.expCount && j < gotRow.size(); j++) begin
            checkOutput($sformatf("v%0d_row%0d_idx", idx, j), 64'(gotRow[j]), 64'(j));
            checkOutput($sformatf("v%0d_row%0d_data", idx, j), gotData[j], v.expY[j]);
        end
        checkOutput($sformatf("v%0d_err", idx), 64'(err), 64'(v.expErr));
        tick();
        checkOutput($sformatf("v%0d_done_pulse_end", idx), 64'(done), 64'd0);
        checkOutput($sformatf("v%0d_idle_busy", idx), 64'(busy), 64'd0);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_addr1"}, 64'(addr1), 64'd0);
        checkOutput({tag, "_addr2"}, 64'(addr2), 64'd0);
        checkOutput({tag, "_rd1"}, 64'(rd1), 64'd0);
        checkOutput({tag, "_rd2"}, 64'(rd2), 64'd0);
        checkOutput({tag, "_busy"}, 64'(busy), 64'd0);
        checkOutput({tag, "_done"}, 64'(done), 64'd0);
        checkOutput({tag, "_y_valid"}, 64'(y_valid), 64'd0);
        checkOutput({tag, "_y_row"}, 64'(y_row), 64'd0);
        checkOutput({tag, "_y_data"}, y_data, 64'd0);
        checkOutput({tag, "_err"}, 64'(err), 64'd0);
    endtask

    // Safety net in case something blocks unexpectedly.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int  seen8;
        int  doneSeen8;
        logic [15:0] data8;
        logic [15:0] row8;

        for (int i = 0; i < 4096; i++) mem[i] = 32'd0;
        for (int i = 0; i < 256; i++) mem8[i] = 8'd0;
        // row_ptr=[0,2,2,3], col=[0,2,1], val=[2,3,4], vec=[5,6,7]
        mem[12'h100] = 0; mem[12'h101] = 2; mem[12'h102] = 2; mem[12'h103] = 3;
        mem[12'h200] = 0; mem[12'h201] = 2; mem[12'h202] = 1;
        mem[12'h300] = 2; mem[12'h301] = 3; mem[12'h302] = 4;
        mem[12'h400] = 5; mem[12'h401] = 6; mem[12'h402] = 7;
        // 8-bit job: one row, val=vec=255 twice
        mem8[8'h10] = 0;   mem8[8'h11] = 2;
        mem8[8'h20] = 0;   mem8[8'h21] = 1;
        mem8[8'h30] = 255; mem8[8'h31] = 255;
        mem8[8'h40] = 255; mem8[8'h41] = 255;

        // nRows nCols col2 stallRow stallLen restart count y0 y1 y2 err firstValid doneEdge
        vecs[0] = mkVec(3, 3, 1, -1, 0, -1, 3, 31, 0, 24, 1'b0, 6, 13);
        vecs[1] = mkVec(3, 3, 1,  1, 3, -1, 3, 31, 0, 24, 1'b0, 6, 16);
        vecs[2] = mkVec(3, 3, 5, -1, 0, -1, 3, 31, 0,  0, 1'b1, 6, 12);
        vecs[3] = mkVec(1, 3, 1, -1, 0, -1, 1, 31, 0,  0, 1'b0, 6, 7);
        vecs[4] = mkVec(0, 3, 1, -1, 0, -1, 0,  0, 0,  0, 1'b0, -1, 1);
        vecs[5] = mkVec(3, 3, 1, -1, 0,  3, 3, 31, 0, 24, 1'b0, 6, 13);

        Rst = 1'b0;
        start = 1'b0; y_ready = 1'b1;
        n_rows = 0; n_cols = 0;
        row_base = 32'h100; col_base = 32'h200; val_base = 32'h300; vec_base = 32'h400;
        start8 = 1'b0; y_ready8 = 1'b1; n_rows8 = 16'd1; n_cols8 = 16'd2;
        #1;
        checkResetValues("reset");
        @(negedge Clk);
        Rst = 1'b1;
        tick();

        for (int i = 0; i < 6; i++) begin
            applyStimulus(i);
        end

        // Address generation, then reset asserted while in VEC.
        mem[12'h202] = 1;
        n_rows = 3; n_cols = 3;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        checkOutput("col_rd1", 64'(rd1), 64'd1);
        checkOutput("col_rd2", 64'(rd2), 64'd1);
        checkOutput("col_addr1", 64'(addr1), 64'h200);
        checkOutput("col_addr2", 64'(addr2), 64'h300);
        tick();
        checkOutput("vec_rd1", 64'(rd1), 64'd0);
        checkOutput("vec_rd2", 64'(rd2), 64'd1);
        checkOutput("vec_addr2", 64'(addr2), 64'h400);
        Rst = 1'b0;
        #1;
        checkResetValues("abort");
        @(negedge Clk);
        Rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput($sformatf("abort_quiet_done%0d", i), 64'(done), 64'd0);
            checkOutput($sformatf("abort_quiet_valid%0d", i), 64'(y_valid), 64'd0);
        end
        applyStimulus(0);

        // 8-bit data / 16-bit accumulator wrap.
        seen8 = 0; doneSeen8 = 0; data8 = 16'd0; row8 = 16'hFFFF;
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        for (int c = 0; c < 40 && doneSeen8 == 0; c++) begin
            if (y_valid8 && seen8 == 0) begin
                seen8 = 1;
                data8 = y_data8;
                row8  = y_row8;
            end
            if (done8) doneSeen8 = 1;
            else tick();
        end
        checkOutput("w8_seen", 64'(seen8), 64'd1);
        checkOutput("w8_data", 64'(data8), 64'hFC02);
        checkOutput("w8_row", 64'(row8), 64'd0);
        checkOutput("w8_done", 64'(doneSeen8), 64'd1);
        checkOutput("w8_err", 64'(err8), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
